// File: rtl/melody_sequencer.sv
// Note-ROM melody player: fetches {divider, duration} words, holds each tone for its
// duration in tempo ticks, inserts a one-tick silent gap, and drives a volume pair.
module melody_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        play,
    input  logic        stop,
    input  logic        loop_en,
    input  logic        tempo_tick,
    input  logic [2:0]  vol_level,
    output logic [5:0]  rom_addr,
    input  logic [23:0] rom_data,
    output logic [19:0] note_div,
    output logic [31:0] vol_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        PLAY,
        GAP
    } state_e;

    state_e      state_q;
    logic [5:0]  rom_addr_q;
    logic [19:0] note_div_q;
    logic [3:0]  dur_cnt_q;
    logic        done_q;
    logic [31:0] vol_data_q;

    logic [15:0] amp_d;
    logic [31:0] vol_data_d;
    logic [3:0]  rom_dur;

    assign rom_dur    = rom_data[3:0];
    assign amp_d      = 16'h4000 >> (3'd7 - vol_level);
    assign vol_data_d = {amp_d, amp_d - 16'd1};

    // The volume pair tracks vol_level in every state, independent of the sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vol_data_q <= 32'h4000_3FFF;
        end else begin
            vol_data_q <= vol_data_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rom_addr_q <= 6'd0;
            note_div_q <= 20'd0;
            dur_cnt_q  <= 4'd0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            done_q <= 1'b0;
            if (stop && state_q != IDLE) begin
                state_q    <= IDLE;
                rom_addr_q <= 6'd0;
                note_div_q <= 20'd0;
                dur_cnt_q  <= 4'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (play && !stop) begin
                            state_q    <= FETCH;
                            rom_addr_q <= 6'd0;
                        end
                    end
                    FETCH: begin
                        state_q <= LOAD;
                    end
                    LOAD: begin
                        if (rom_dur != 4'd0) begin
                            state_q    <= PLAY;
                            note_div_q <= rom_data[23:4];
                            dur_cnt_q  <= rom_dur;
                        end else if (loop_en) begin
                            state_q    <= FETCH;
                            rom_addr_q <= 6'd0;
                        end else begin
                            state_q    <= IDLE;
                            rom_addr_q <= 6'd0;
                            done_q     <= 1'b1;
                        end
                    end
                    PLAY: begin
                        if (tempo_tick) begin
                            if (dur_cnt_q == 4'd1) begin
                                state_q    <= GAP;
                                note_div_q <= 20'd0;
                            end
                            dur_cnt_q <= dur_cnt_q - 4'd1;
                        end
                    end
                    GAP: begin
                        // Address wraps 63 -> 0 through natural 6-bit overflow.
                        if (tempo_tick) begin
                            state_q    <= FETCH;
                            rom_addr_q <= rom_addr_q + 6'd1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign rom_addr = rom_addr_q;
    assign note_div = note_div_q;
    assign vol_data = vol_data_q;
    assign done     = done_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer: behavioural one-cycle ROM, hand-computed
// expectations for playback, looping, stop, address wrap, volume and async reset.
module tb_melody_sequencer;

    logic        clk;
    logic        rst_n;
    logic        play;
    logic        stop;
    logic        loop_en;
    logic        tempo_tick;
    logic [2:0]  vol_level;
    logic [5:0]  rom_addr;
    logic [23:0] rom_data;
    logic [19:0] note_div;
    logic [31:0] vol_data;
    logic        busy;
    logic        done;

    logic [23:0] rom [64];
    int          checks;
    int          errors;
    int          done_cnt;
    int          done_base;

    melody_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .play       (play),
        .stop       (stop),
        .loop_en    (loop_en),
        .tempo_tick (tempo_tick),
        .vol_level  (vol_level),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .note_div   (note_div),
        .vol_data   (vol_data),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tempo_tick = 1'b1;
        step();
        tempo_tick = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic load_song();
        for (int i = 0; i < 64; i++) rom[i] = 24'h0;
        rom[0] = 24'h01000_2;
        rom[1] = 24'h02000_1;
        rom[2] = 24'h00000_0;
    endtask

    logic [31:0] vol_tab [8];
    logic [31:0] prev_vol;

    initial begin
        checks = 0; errors = 0; done_cnt = 0;
        vol_tab[0] = 32'h0080_007F; vol_tab[1] = 32'h0100_00FF;
        vol_tab[2] = 32'h0200_01FF; vol_tab[3] = 32'h0400_03FF;
        vol_tab[4] = 32'h0800_07FF; vol_tab[5] = 32'h1000_0FFF;
        vol_tab[6] = 32'h2000_1FFF; vol_tab[7] = 32'h4000_3FFF;
        load_song();
        rst_n = 1'b1; play = 1'b0; stop = 1'b0; loop_en = 1'b0;
        tempo_tick = 1'b0; vol_level = 3'd7;
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_note", note_div, 0);
        check("rst_done", done, 0);
        check("rst_vol", vol_data, 32'h4000_3FFF);
        step(); step();
        rst_n = 1'b1;
        step();
        pulse_tick();
        check("idle_tick_ignored", busy, 0);

        // Song once through, no loop
        done_base = done_cnt;
        play = 1'b1; step(); play = 1'b0;
        check("s1_fetch_busy", busy, 1);
        check("s1_fetch_addr", rom_addr, 0);
        check("s1_fetch_note", note_div, 0);
        step();
        check("s1_load_note", note_div, 0);
        step();
        check("s1_play_n0", note_div, 20'h01000);
        play = 1'b1; step(); play = 1'b0;
        check("s1_play_ignored_note", note_div, 20'h01000);
        check("s1_play_ignored_addr", rom_addr, 0);
        pulse_tick();
        check("s1_n0_tick1", note_div, 20'h01000);
        pulse_tick();
        check("s1_gap0_note", note_div, 0);
        check("s1_gap0_busy", busy, 1);
        pulse_tick();
        check("s1_fetch1_addr", rom_addr, 1);
        step(); step();
        check("s1_play_n1", note_div, 20'h02000);
        pulse_tick();
        check("s1_gap1_note", note_div, 0);
        pulse_tick();
        check("s1_fetch2_addr", rom_addr, 2);
        step();
        check("s1_load_end_done", done, 0);
        step();
        check("s1_end_done", done, 1);
        check("s1_end_busy", busy, 0);
        step();
        check("s1_done_cleared", done, 0);
        check("s1_done_once", done_cnt - done_base, 1);

        // Same song with looping
        done_base = done_cnt;
        loop_en = 1'b1;
        play = 1'b1; step(); play = 1'b0;
        step(); step();
        check("s2_play_n0", note_div, 20'h01000);
        pulse_tick(); pulse_tick(); pulse_tick();
        step(); step();
        check("s2_play_n1", note_div, 20'h02000);
        pulse_tick(); pulse_tick();
        step();
        step();
        check("s2_loop_addr", rom_addr, 0);
        check("s2_loop_busy", busy, 1);
        check("s2_loop_done", done, 0);
        step(); step();
        check("s2_loop_n0", note_div, 20'h01000);
        loop_en = 1'b0;
        do_stop();
        check("s2_stop_busy", busy, 0);
        check("s2_no_done", done_cnt - done_base, 0);

        // Stop during note 2, then restart with ticks arriving during FETCH/LOAD
        done_base = done_cnt;
        play = 1'b1; step(); play = 1'b0;
        step(); step();
        pulse_tick(); pulse_tick(); pulse_tick();
        step(); step();
        check("s3_play_n1", note_div, 20'h02000);
        do_stop();
        check("s3_stop_note", note_div, 0);
        check("s3_stop_busy", busy, 0);
        check("s3_stop_addr", rom_addr, 0);
        check("s3_stop_no_done", done_cnt - done_base, 0);
        play = 1'b1; tempo_tick = 1'b1;
        step(); play = 1'b0;
        step(); step();
        tempo_tick = 1'b0;
        check("s3_restart_n0", note_div, 20'h01000);
        check("s3_restart_addr", rom_addr, 0);
        pulse_tick();
        check("s3_ticks_not_queued", note_div, 20'h01000);
        pulse_tick();
        check("s3_gap_note", note_div, 0);
        do_stop();

        // Address wrap: 64 one-tick notes, no end marker
        done_base = done_cnt;
        for (int i = 0; i < 64; i++) rom[i] = {20'(i + 1), 4'd1};
        play = 1'b1; step(); play = 1'b0;
        for (int i = 0; i < 64; i++) begin
            check($sformatf("s4_addr_%0d", i), rom_addr, i);
            step(); step();
            check($sformatf("s4_note_%0d", i), note_div, i + 1);
            pulse_tick(); pulse_tick();
        end
        check("s4_wrap_addr", rom_addr, 0);
        check("s4_wrap_busy", busy, 1);
        step(); step();
        check("s4_wrap_note", note_div, 1);
        check("s4_no_done", done_cnt - done_base, 0);
        do_stop();

        // Volume sweep during PLAY
        load_song();
        play = 1'b1; step(); play = 1'b0;
        step(); step();
        prev_vol = 32'h4000_3FFF;
        for (int v = 0; v < 8; v++) begin
            vol_level = 3'(v);
            check($sformatf("s5_vol_hold_%0d", v), vol_data, prev_vol);
            step();
            check($sformatf("s5_vol_%0d", v), vol_data, vol_tab[v]);
            check($sformatf("s5_note_%0d", v), note_div, 20'h01000);
            prev_vol = vol_tab[v];
        end

        // Asynchronous reset mid-PLAY
        vol_level = 3'd2;
        step();
        check("s6_pre_vol", vol_data, 32'h0200_01FF);
        check("s6_pre_note", note_div, 20'h01000);
        #3 rst_n = 1'b0;
        #1;
        check("s6_arst_note", note_div, 0);
        check("s6_arst_busy", busy, 0);
        check("s6_arst_addr", rom_addr, 0);
        check("s6_arst_done", done, 0);
        check("s6_arst_vol", vol_data, 32'h4000_3FFF);
        step();
        #2 rst_n = 1'b1;
        vol_level = 3'd7;
        step();
        play = 1'b1; stop = 1'b1;
        step();
        play = 1'b0; stop = 1'b0;
        check("s6_play_stop_busy", busy, 0);
        step();
        check("s6_still_idle", busy, 0);
        play = 1'b1; step(); play = 1'b0;
        check("s6_restart_busy", busy, 1);
        check("s6_restart_addr", rom_addr, 0);
        step(); step();
        check("s6_restart_n0", note_div, 20'h01000);
        do_stop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
